// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and
// the per-stage destination tags carried by the shadow pipeline.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } stage_tag_t;

  localparam stage_tag_t TAG_EMPTY = '0;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Operand forwarding select for the instruction in ID, compared against the
// EX and MEM shadow tags that it will see as EX/MEM and MEM/WB one cycle later.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic              rs_used,
  input  stage_tag_t        ex_tag,
  input  stage_tag_t        mem_tag,
  output fwd_sel_e          sel_c
);

  logic ex_hit;
  logic mem_hit;
  logic unused_load;

  assign unused_load = ex_tag.load ^ mem_tag.load;

  assign ex_hit  = ex_tag.valid  && ex_tag.we  && (ex_tag.rd  == rs);
  assign mem_hit = mem_tag.valid && mem_tag.we && (mem_tag.rd == rs);

  // Younger producer wins; x0 and unread operands never forward.
  always_comb begin
    sel_c = FWD_RF;
    if (rs_used && (rs != '0)) begin
      if (ex_hit) begin
        sel_c = FWD_EXMEM;
      end else if (mem_hit) begin
        sel_c = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall / flush / forwarding controller for the 5-stage RV32I pipeline.
// Tracks in-flight destinations in an EX/MEM/WB shadow pipeline.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_muldiv,
  input  logic              ex_branch_taken,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_id,
  output logic              hold_ex,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic              freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              we_bypass,
  output logic              we_stall,
  output logic [REG_AW-1:0] curr_rd
);

  localparam int unsigned CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MULDIV_LAT - 1);

  stage_tag_t        ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0]  busy_q, busy_d;
  fwd_sel_e          fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  fwd_sel_e          sel_a_c, sel_b_c;
  logic [REG_AW-1:0] curr_rd_q, curr_rd_d;

  logic freeze_c;
  logic busy_c;
  logic load_use_c;
  logic unused_wb;

  // WB is tracked for completeness; the write-first regfile needs no WB bypass.
  assign unused_wb = ^wb_q;

  fwd_select u_fwd_a (
    .rs      (id_rs1),
    .rs_used (id_rs1_used),
    .ex_tag  (ex_q),
    .mem_tag (mem_q),
    .sel_c   (sel_a_c)
  );

  fwd_select u_fwd_b (
    .rs      (id_rs2),
    .rs_used (id_rs2_used),
    .ex_tag  (ex_q),
    .mem_tag (mem_q),
    .sel_c   (sel_b_c)
  );

  assign freeze_c   = ~mem_ready;
  assign busy_c     = (busy_q != '0);
  assign load_use_c = id_valid && ex_q.valid && ex_q.load && ex_q.we && (ex_q.rd != '0) &&
                      ((id_rs1_used && (id_rs1 == ex_q.rd)) ||
                       (id_rs2_used && (id_rs2 == ex_q.rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= TAG_EMPTY;
      mem_q     <= TAG_EMPTY;
      wb_q      <= TAG_EMPTY;
      busy_q    <= '0;
      fwd_a_q   <= FWD_RF;
      fwd_b_q   <= FWD_RF;
      curr_rd_q <= '0;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      busy_q    <= busy_d;
      fwd_a_q   <= fwd_a_d;
      fwd_b_q   <= fwd_b_d;
      curr_rd_q <= curr_rd_d;
    end
  end

  // Shadow pipeline advance: freeze holds all, mul/div busy drains MEM/WB only.
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    busy_d  = busy_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (freeze_c) begin
      busy_d = busy_q;
    end else if (busy_c) begin
      mem_d  = TAG_EMPTY;
      wb_d   = mem_q;
      busy_d = busy_q - CNT_W'(1);
    end else begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bubble_ex || !id_valid) begin
        ex_d    = TAG_EMPTY;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
      end else begin
        ex_d.valid = 1'b1;
        ex_d.rd    = id_rd;
        ex_d.we    = id_we;
        ex_d.load  = id_is_load;
        fwd_a_d    = sel_a_c;
        fwd_b_d    = sel_b_c;
        if (id_is_muldiv) begin
          busy_d = BUSY_LOAD;
        end
      end
    end
    curr_rd_d = (ex_d.valid && ex_d.we) ? ex_d.rd : '0;
  end

  // Control outputs in priority order: freeze, mul/div busy, branch, load-use.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    hold_ex   = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    if (freeze_c) begin
      freeze   = 1'b1;
      stall_if = 1'b1;
      stall_id = 1'b1;
      hold_ex  = 1'b1;
    end else if (busy_c) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      hold_ex  = 1'b1;
    end else if (ex_branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use_c) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign we_bypass = (fwd_a_q != FWD_RF) || (fwd_b_q != FWD_RF);
  assign we_stall  = stall_id;
  assign curr_rd   = curr_rd_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction sequences push the
// expected per-cycle output word; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       md;
  } ins_t;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110100;
  localparam logic [5:0] C_BUSY = 6'b111000;
  localparam logic [5:0] C_FRZ  = 6'b111001;
  localparam logic [5:0] C_BR   = 6'b000110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       id_we = 1'b0, id_is_load = 1'b0, id_is_muldiv = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       mem_ready = 1'b1;
  logic       stall_if, stall_id, hold_ex, bubble_ex, flush_id, freeze;
  logic [1:0] fwd_a, fwd_b;
  logic       we_bypass, we_stall;
  logic [4:0] curr_rd;

  logic [16:0] exp_q[$];
  string       name_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_LAT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_we           (id_we),
    .id_is_load      (id_is_load),
    .id_is_muldiv    (id_is_muldiv),
    .ex_branch_taken (ex_branch_taken),
    .mem_ready       (mem_ready),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .hold_ex         (hold_ex),
    .bubble_ex       (bubble_ex),
    .flush_id        (flush_id),
    .freeze          (freeze),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .we_bypass       (we_bypass),
    .we_stall        (we_stall),
    .curr_rd         (curr_rd)
  );

  // Expected word: {stall_if,stall_id,hold_ex,bubble_ex,flush_id,freeze,fwd_a,fwd_b,we_bypass,we_stall,curr_rd}
  function automatic logic [16:0] ev(logic [5:0] c, logic [1:0] fa, logic [1:0] fb, logic [4:0] rd);
    logic byp;
    byp = (fa != 2'b00) || (fb != 2'b00);
    return {c, fa, fb, byp, c[4], rd};
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = '0;
    return i;
  endfunction

  function automatic ins_t alu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    ins_t i;
    i = '0;
    i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.u1 = 1'b1; i.u2 = 1'b1; i.we = 1'b1;
    return i;
  endfunction

  function automatic ins_t lw(logic [4:0] rd, logic [4:0] rs1);
    ins_t i;
    i = alu(rd, rs1, 5'd0);
    i.u2 = 1'b0; i.ld = 1'b1;
    return i;
  endfunction

  function automatic ins_t mul(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    ins_t i;
    i = alu(rd, rs1, rs2);
    i.md = 1'b1;
    return i;
  endfunction

  task automatic step(input string nm, input ins_t i, input logic br, input logic mr,
                      input logic r, input logic [16:0] e);
    @(posedge clk);
    #1;
    rst             = r;
    id_valid        = i.v;
    id_rs1          = i.rs1;
    id_rs2          = i.rs2;
    id_rs1_used     = i.u1;
    id_rs2_used     = i.u2;
    id_rd           = i.rd;
    id_we           = i.we;
    id_is_load      = i.ld;
    id_is_muldiv    = i.md;
    ex_branch_taken = br;
    mem_ready       = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every cycle the DUT presents a full control word.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [16:0] e;
      logic [16:0] a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {stall_if, stall_id, hold_ex, bubble_ex, flush_id, freeze,
            fwd_a, fwd_b, we_bypass, we_stall, curr_rd};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", nm, a, e);
      end
    end
  end

  initial begin
    logic [16:0] e0;
    e0 = ev(C_NONE, 2'b00, 2'b00, 5'd0);
    repeat (2) @(posedge clk);
    step("reset",     nop(), 1'b0, 1'b1, 1'b1, e0);
    step("idle",      nop(), 1'b0, 1'b1, 1'b0, e0);

    step("exmem_add", alu(5, 1, 2),  1'b0, 1'b1, 1'b0, e0);
    step("exmem_sub", alu(6, 5, 1),  1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b00, 2'b00, 5'd5));
    step("exmem_fwd", nop(),         1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b01, 2'b00, 5'd6));
    step("exmem_d1",  nop(),         1'b0, 1'b1, 1'b0, e0);
    step("exmem_d2",  nop(),         1'b0, 1'b1, 1'b0, e0);

    step("memwb_add", alu(5, 1, 2),  1'b0, 1'b1, 1'b0, e0);
    step("memwb_xor", alu(10, 3, 4), 1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b00, 2'b00, 5'd5));
    step("memwb_sub", alu(6, 5, 1),  1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b00, 2'b00, 5'd10));
    step("memwb_fwd", nop(),         1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b10, 2'b00, 5'd6));
    step("memwb_d1",  nop(),         1'b0, 1'b1, 1'b0, e0);
    step("memwb_d2",  nop(),         1'b0, 1'b1, 1'b0, e0);

    step("lu_lw",     lw(7, 2),      1'b0, 1'b1, 1'b0, e0);
    step("lu_stall",  alu(8, 7, 7),  1'b0, 1'b1, 1'b0, ev(C_LU, 2'b00, 2'b00, 5'd7));
    step("lu_after",  alu(8, 7, 7),  1'b0, 1'b1, 1'b0, e0);
    step("lu_fwd",    nop(),         1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b10, 2'b10, 5'd8));
    step("lu_d1",     nop(),         1'b0, 1'b1, 1'b0, e0);
    step("lu_d2",     nop(),         1'b0, 1'b1, 1'b0, e0);

    step("x0_lw",     lw(0, 3),      1'b0, 1'b1, 1'b0, e0);
    step("x0_use",    alu(11, 0, 0), 1'b0, 1'b1, 1'b0, e0);
    step("x0_nofwd",  nop(),         1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b00, 2'b00, 5'd11));
    step("x0_d1",     nop(),         1'b0, 1'b1, 1'b0, e0);
    step("x0_d2",     nop(),         1'b0, 1'b1, 1'b0, e0);

    step("md_mul",    mul(9, 1, 2),  1'b0, 1'b1, 1'b0, e0);
    for (int k = 0; k < 3; k++)
      step("md_busy", alu(13, 9, 0), 1'b0, 1'b1, 1'b0, ev(C_BUSY, 2'b00, 2'b00, 5'd9));
    step("md_done",   alu(13, 9, 0), 1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b00, 2'b00, 5'd9));
    step("md_fwd",    nop(),         1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b01, 2'b00, 5'd13));
    step("md_d1",     nop(),         1'b0, 1'b1, 1'b0, e0);
    step("md_d2",     nop(),         1'b0, 1'b1, 1'b0, e0);

    step("mdf_mul",   mul(9, 1, 2),  1'b0, 1'b1, 1'b0, e0);
    step("mdf_busy0", alu(13, 9, 0), 1'b0, 1'b1, 1'b0, ev(C_BUSY, 2'b00, 2'b00, 5'd9));
    for (int k = 0; k < 2; k++)
      step("mdf_frz", alu(13, 9, 0), 1'b0, 1'b0, 1'b0, ev(C_FRZ, 2'b00, 2'b00, 5'd9));
    for (int k = 0; k < 2; k++)
      step("mdf_busy", alu(13, 9, 0), 1'b0, 1'b1, 1'b0, ev(C_BUSY, 2'b00, 2'b00, 5'd9));
    step("mdf_done",  alu(13, 9, 0), 1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b00, 2'b00, 5'd9));
    step("mdf_fwd",   nop(),         1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b01, 2'b00, 5'd13));
    step("mdf_d1",    nop(),         1'b0, 1'b1, 1'b0, e0);
    step("mdf_d2",    nop(),         1'b0, 1'b1, 1'b0, e0);

    step("br_lw",     lw(7, 2),      1'b0, 1'b1, 1'b0, e0);
    step("br_flush",  alu(8, 7, 7),  1'b1, 1'b1, 1'b0, ev(C_BR, 2'b00, 2'b00, 5'd7));
    step("br_d1",     nop(),         1'b0, 1'b1, 1'b0, e0);
    step("br_d2",     nop(),         1'b0, 1'b1, 1'b0, e0);

    step("prio_a",    alu(5, 1, 2),  1'b0, 1'b1, 1'b0, e0);
    step("prio_b",    alu(5, 3, 4),  1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b00, 2'b00, 5'd5));
    step("prio_sub",  alu(6, 5, 5),  1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b00, 2'b00, 5'd5));
    step("prio_fwd",  nop(),         1'b0, 1'b1, 1'b0, ev(C_NONE, 2'b01, 2'b01, 5'd6));
    step("prio_d1",   nop(),         1'b0, 1'b1, 1'b0, e0);
    step("prio_d2",   nop(),         1'b0, 1'b1, 1'b0, e0);

    step("rst_mul",   mul(9, 1, 2),  1'b0, 1'b1, 1'b0, e0);
    step("rst_busy",  alu(13, 9, 0), 1'b0, 1'b1, 1'b0, ev(C_BUSY, 2'b00, 2'b00, 5'd9));
    step("rst_hit",   alu(13, 9, 0), 1'b0, 1'b1, 1'b1, ev(C_BUSY, 2'b00, 2'b00, 5'd9));
    step("rst_clear", nop(),         1'b0, 1'b1, 1'b0, e0);
    step("rst_idle",  nop(),         1'b0, 1'b1, 1'b0, e0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
